// File: rtl/mem_ctrl.sv
// Word-addressed memory controller: one read/write at a time, fixed LATENCY, one-cycle done pulse.
// Optional even-parity protection of the array is enabled by defining MEM_CTRL_PARITY_EN.
module mem_ctrl #(
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 2,
    parameter int WORD_SIZE  = 16,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rden_in,
    input  logic                  wren_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [WORD_SIZE-1:0]  data_in,
    output logic [WORD_SIZE-1:0]  data_out,
    output logic                  mem_ret_out,
    output logic                  err_out
);

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef enum logic { OP_BUSY = 1'b0, OP_DONE = 1'b1 } op_t;
    typedef enum logic [1:0] { S_IDLE, S_ACCESS, S_DONE } state_t;

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [3:0]          CNT_LOAD = 4'(LATENCY - 1);
`ifdef MEM_CTRL_PARITY_EN
    localparam int MEM_W = WORD_SIZE + 1;
`else
    localparam int MEM_W = WORD_SIZE;
`endif

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   op_rd_q, op_rd_d;
    addr_t                  addr_q, addr_d;
    logic [WORD_SIZE-1:0]   wdata_q, wdata_d;
    logic [WORD_SIZE-1:0]   data_out_q, data_out_d;
    logic                   err_q, err_d;

    logic [MEM_W-1:0]       mem_q [DEPTH];
    logic [MEM_W-1:0]       rd_word;
    logic [MEM_W-1:0]       wr_word;
    logic [IDX_W-1:0]       idx;
    logic                   in_range;
    logic                   rd_perr;
    logic                   mem_we;

    assign idx      = addr_q[IDX_W-1:0];
    assign in_range = {1'b0, addr_q} < DEPTH_W;
    assign rd_word  = mem_q[idx];

`ifdef MEM_CTRL_PARITY_EN
    // Parity bit makes the stored word's total popcount even.
    assign wr_word = {^wdata_q, wdata_q};
    assign rd_perr = ^rd_word;
`else
    assign wr_word = wdata_q;
    assign rd_perr = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_rd_d    = op_rd_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        data_out_d = data_out_q;
        err_d      = err_q;
        mem_we     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rden_in || wren_in) begin
                    op_rd_d = rden_in;
                    addr_d  = addr_in;
                    wdata_d = data_in;
                    cnt_d   = CNT_LOAD;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_DONE;
                    if (!in_range) begin
                        err_d = 1'b1;
                        if (op_rd_q) data_out_d = '0;
                    end else if (op_rd_q) begin
                        data_out_d = rd_word[WORD_SIZE-1:0];
                        err_d      = rd_perr;
                    end else begin
                        mem_we = 1'b1;
                        err_d  = 1'b0;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                err_d   = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            op_rd_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            data_out_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_rd_q    <= op_rd_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            data_out_q <= data_out_d;
            err_q      <= err_d;
        end
    end

    // Array is never reset; an aborted op cannot write because reset forces state out of ACCESS.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[idx] <= wr_word;
    end

    assign data_out    = data_out_q;
    assign err_out     = err_q;
    assign mem_ret_out = (state_q == S_DONE) ? OP_DONE : OP_BUSY;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: driver pushes expected results, a negedge monitor checks each done.
module tb_mem_ctrl;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;
    localparam int WS    = 16;
    localparam int AW    = 11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rden_in = 1'b0;
    logic          wren_in = 1'b0;
    logic [AW-1:0] addr_in = '0;
    logic [WS-1:0] data_in = '0;
    logic [WS-1:0] data_out;
    logic          mem_ret_out;
    logic          err_out;

    mem_ctrl #(.DEPTH(DEPTH), .LATENCY(LAT), .WORD_SIZE(WS), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .rden_in(rden_in), .wren_in(wren_in),
        .addr_in(addr_in), .data_in(data_in), .data_out(data_out),
        .mem_ret_out(mem_ret_out), .err_out(err_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct { logic [WS-1:0] data; logic err; string name; } exp_t;
    exp_t sb[$];

    logic [WS-1:0] model_mem [int];
    logic [WS-1:0] last_rd = '0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: reads return the model word (or 0 + error when out of range); writes keep last read data.
    function automatic exp_t predict(bit rd, bit wr, int a, logic [WS-1:0] d, string name);
        exp_t e;
        e.name = name;
        e.err  = (a >= DEPTH);
        if (rd) begin
            e.data  = (a < DEPTH) ? model_mem[a] : '0;
            last_rd = e.data;
        end else begin
            if (wr && a < DEPTH) model_mem[a] = d;
            e.data = last_rd;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && mem_ret_out) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_data"}, 32'(data_out), 32'(e.data));
                check({e.name, "_err"}, 32'(err_out), 32'(e.err));
                $display("txn %s data=%h err=%0d", e.name, data_out, err_out);
            end
        end
    end

    // Issue one op, optionally glitching wren_in/addr_in for one ACCESS cycle, and time the done pulse.
    task automatic do_op(bit rd, bit wr, int a, logic [WS-1:0] d, string name,
                         bit glitch = 0, int ga = 0);
        int k;
        rden_in = rd; wren_in = wr; addr_in = AW'(a); data_in = d;
        sb.push_back(predict(rd, wr, a, d, name));
        @(posedge clk); #1;
        rden_in = 1'b0; wren_in = 1'b0;
        k = 0;
        if (glitch) begin
            wren_in = 1'b1; addr_in = AW'(ga); data_in = ~d;
            @(posedge clk); #1;
            wren_in = 1'b0;
            k = 1;
        end
        while (k < 20) begin
            @(posedge clk); #1;
            k++;
            if (mem_ret_out) break;
        end
        check({name, "_latency"}, 32'(k), 32'(LAT));
        @(posedge clk); #1;
        check({name, "_busy_after"}, 32'(mem_ret_out), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WS-1:0] v;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ret", 32'(mem_ret_out), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_err", 32'(err_out), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(0, 1, 5, 16'h1234, "wr5");
        do_op(1, 0, 5, 16'h0000, "rd5");

        do_op(0, 1, 7, 16'h00AA, "wr7");
        do_op(1, 1, 7, 16'h0055, "both7");
        do_op(1, 0, 7, 16'h0000, "rd7");

        do_op(0, 1, DEPTH, 16'hDEAD, "wr_oor");
        do_op(1, 0, DEPTH, 16'h0000, "rd_oor");
        do_op(1, 0, DEPTH - 1 + 1 - 1, 16'h0, "rd_last_unwritten_skip_guard");

        // Glitch test: the write to 10 must complete alone; 11 keeps its value.
        do_op(0, 1, 11, 16'h1111, "wr11");
        do_op(0, 1, 10, 16'hA5A5, "wr10_glitch", 1, 11);
        do_op(1, 0, 11, 16'h0, "rd11");
        do_op(1, 0, 10, 16'h0, "rd10");

        // Reset one cycle into ACCESS of a write aborts it.
        do_op(0, 1, 3, 16'h0001, "wr3");
        wren_in = 1'b1; addr_in = AW'(3); data_in = 16'hBEEF;
        @(posedge clk); #1;
        wren_in = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_ret", 32'(mem_ret_out), 32'd0);
        check("abort_data", 32'(data_out), 32'd0);
        check("abort_err", 32'(err_out), 32'd0);
        @(posedge clk); #1;
        check("abort_no_done", 32'(mem_ret_out), 32'd0);
        rst_n = 1'b1;
        last_rd = '0;
        @(posedge clk); #1;
        do_op(1, 0, 3, 16'h0, "rd3_after_abort");

        // Flip a stored bit: parity build flags it, plain build just returns the flipped word.
        v = 16'h0F0F;
        do_op(0, 1, 9, v, "wr9");
        dut.mem_q[9][0] = ~dut.mem_q[9][0];
        model_mem[9] = v ^ 16'h0001;
        rden_in = 1'b1; addr_in = AW'(9);
        begin
            exp_t e;
            e = predict(1, 0, 9, '0, "rd9_flip");
`ifdef MEM_CTRL_PARITY_EN
            e.err = 1'b1;
`endif
            sb.push_back(e);
        end
        @(posedge clk); #1;
        rden_in = 1'b0;
        repeat (LAT + 1) @(posedge clk);
        #1;

        for (int i = 32; i < 48; i++) do_op(0, 1, i, 16'($urandom), "init");
        for (int n = 0; n < 40; n++) begin
            int  a;
            bit  rd, wr;
            a  = ($urandom_range(0, 7) == 0) ? DEPTH + $urandom_range(0, 1023) : $urandom_range(32, 47);
            rd = $urandom_range(0, 1);
            wr = rd ? bit'($urandom_range(0, 1)) : 1'b1;
            do_op(rd, wr, a, 16'($urandom), "rand");
        end

        repeat (5) @(posedge clk);
        #1;
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
